// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter that lets several producers share one FIFO
// write port. The winner of an arbitration owns the port for a burst of up to
// MAX_BURST beats, or until it drops valid. Priority then rotates to the
// producer after the owner. Data goes from producer to FIFO with no register
// in between, so fifo_full is always current and the FIFO cannot overflow.
module fifo_wr_arbiter #(
    parameter int DataWidth = 16,
    parameter int NumReq    = 4,
    parameter int MAX_BURST = 8,
    parameter int IdWidth   = $clog2(NumReq)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NumReq-1:0]           req_valid,
    input  logic [NumReq*DataWidth-1:0] req_data,
    output logic [NumReq-1:0]           req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr,
    output logic [DataWidth-1:0]        fifo_data,
    output logic [IdWidth-1:0]          grant_id,
    output logic                        busy
);

    // beat_cnt only has to reach MAX_BURST-1; keep at least one bit.
    localparam int CntWidth = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state_reg, state_next;
    logic [IdWidth-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IdWidth-1:0]     grant_id_reg, grant_id_next;
    logic [CntWidth-1:0]    beat_cnt_reg, beat_cnt_next;

    logic [IdWidth-1:0]     winner;
    logic                   any_valid;
    logic                   transfer;
    logic [IdWidth-1:0]     after_owner;
    logic [DataWidth-1:0]   req_words [NumReq];

    // Index arithmetic modulo NumReq; works for non-power-of-two counts.
    function automatic logic [IdWidth-1:0] wrap_add(input logic [IdWidth-1:0] base,
                                                    input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return IdWidth'(sum);
    endfunction

    // Per-producer word slices and per-producer ready decode.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign req_words[gi] = req_data[gi*DataWidth +: DataWidth];
            assign req_ready[gi] = busy & (grant_id_reg == IdWidth'(gi)) & ~fifo_full;
        end
    endgenerate

    // Rotating-priority search: first valid producer at or after rr_ptr.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NumReq; k++) begin
            if (!any_valid && req_valid[wrap_add(rr_ptr_reg, k)]) begin
                any_valid = 1'b1;
                winner    = wrap_add(rr_ptr_reg, k);
            end
        end
    end

    // State register; asynchronous reset drops ready/wr the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in BURST.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        beat_cnt_next = beat_cnt_reg;
        after_owner   = wrap_add(grant_id_reg, 1);
        case (state_reg)
            IDLE: begin
                if (any_valid) begin
                    grant_id_next = winner;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                if (!req_valid[grant_id_reg]) begin
                    // Owner gave up the port; nothing written this cycle.
                    state_next  = IDLE;
                    rr_ptr_next = after_owner;
                end else if (transfer) begin
                    if (beat_cnt_reg == LastBeat) begin
                        state_next  = IDLE;
                        rr_ptr_next = after_owner;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
                // Valid but FIFO full: hold everything, no timeout.
            end
        endcase
    end

    // Output decode: steer the owner's word to the FIFO when a beat moves.
    always_comb begin
        busy      = (state_reg == BURST);
        grant_id  = grant_id_reg;
        transfer  = req_valid[grant_id_reg] & req_ready[grant_id_reg];
        fifo_wr   = transfer;
        fifo_data = busy ? req_words[grant_id_reg] : '0;
    end

endmodule
